// File: rtl/apply_bound_mask_32bit.sv
// Read-modify-write painter for one 32-bit packed image word: reads the word,
// sets or clears the run from the bound to the chosen word edge, writes it back.
module apply_bound_mask_32bit #(
  parameter int ADDR_WIDTH = 13,
  parameter int RD_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_trig,
  input  logic [ADDR_WIDTH-1:0] i_bram_addr,
  input  logic [4:0]            i_bound_index,
  input  logic                  i_left_or_right,
  input  logic                  i_is_bound_valid,
  input  logic                  i_fill_value,
  output logic                  o_bram_en,
  output logic                  o_bram_we,
  output logic [ADDR_WIDTH-1:0] o_bram_addr,
  output logic [31:0]           o_bram_wdata,
  input  logic [31:0]           i_bram_rdata,
  output logic [31:0]           o_word_out,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);

  // Left covers bit 31 down to idx, right covers idx down to bit 0; never empty.
  function automatic logic [31:0] bound_mask(input logic [4:0] idx, input logic left);
    if (left) begin
      bound_mask = 32'hFFFF_FFFF << idx;
    end else begin
      bound_mask = 32'hFFFF_FFFF >> (5'd31 - idx);
    end
  endfunction

  function automatic logic [31:0] paint_word(input logic [31:0] word, input logic [31:0] mask,
                                             input logic fill);
    if (fill) begin
      paint_word = word | mask;
    end else begin
      paint_word = word & ~mask;
    end
  endfunction

  state_t                  state_r, state_s;
  logic [1:0]              wait_cnt_r, wait_cnt_s;
  logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
  logic [4:0]              index_r, index_s;
  logic                    left_r, left_s;
  logic                    valid_r, valid_s;
  logic                    fill_r, fill_s;
  logic                    bram_en_r, bram_en_s;
  logic                    bram_we_r, bram_we_s;
  logic [ADDR_WIDTH-1:0]   bram_addr_r, bram_addr_s;
  logic [31:0]             bram_wdata_r, bram_wdata_s;
  logic [31:0]             word_out_r, word_out_s;
  logic                    busy_r, busy_s;
  logic                    done_r, done_s;
  logic [31:0]             new_word_s;

  assign new_word_s   = paint_word(i_bram_rdata, bound_mask(index_r, left_r), fill_r);
  assign o_bram_en    = bram_en_r;
  assign o_bram_we    = bram_we_r;
  assign o_bram_addr  = bram_addr_r;
  assign o_bram_wdata = bram_wdata_r;
  assign o_word_out   = word_out_r;
  assign o_busy       = busy_r;
  assign o_done       = done_r;

  // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
  always_comb begin
    state_s      = state_r;
    wait_cnt_s   = wait_cnt_r;
    addr_s       = addr_r;
    index_s      = index_r;
    left_s       = left_r;
    valid_s      = valid_r;
    fill_s       = fill_r;
    bram_en_s    = 1'b0;
    bram_we_s    = 1'b0;
    bram_addr_s  = bram_addr_r;
    bram_wdata_s = bram_wdata_r;
    word_out_s   = word_out_r;
    busy_s       = 1'b1;
    done_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_trig) begin
          addr_s      = i_bram_addr;
          index_s     = i_bound_index;
          left_s      = i_left_or_right;
          valid_s     = i_is_bound_valid;
          fill_s      = i_fill_value;
          bram_en_s   = 1'b1;
          bram_addr_s = i_bram_addr;
          state_s     = ST_RD;
        end else begin
          busy_s = 1'b0;
        end
      end
      ST_RD: begin
        wait_cnt_s = 2'd0;
        state_s    = ST_WAIT;
      end
      ST_WAIT: begin
        // Read data is valid during the last WAIT cycle; the write word is built from it directly.
        if (wait_cnt_r == WAIT_LAST) begin
          state_s = ST_WR;
          if (valid_r) begin
            bram_en_s    = 1'b1;
            bram_we_s    = 1'b1;
            bram_addr_s  = addr_r;
            bram_wdata_s = new_word_s;
            word_out_s   = new_word_s;
          end else begin
            word_out_s = i_bram_rdata;
          end
        end else begin
          wait_cnt_s = wait_cnt_r + 2'd1;
        end
      end
      ST_WR: begin
        done_s  = 1'b1;
        state_s = ST_DONE;
      end
      ST_DONE: begin
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, operand and output registers; reset clears write enable immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r      <= ST_IDLE;
      wait_cnt_r   <= 2'd0;
      addr_r       <= '0;
      index_r      <= 5'd0;
      left_r       <= 1'b0;
      valid_r      <= 1'b0;
      fill_r       <= 1'b0;
      bram_en_r    <= 1'b0;
      bram_we_r    <= 1'b0;
      bram_addr_r  <= '0;
      bram_wdata_r <= 32'd0;
      word_out_r   <= 32'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      wait_cnt_r   <= wait_cnt_s;
      addr_r       <= addr_s;
      index_r      <= index_s;
      left_r       <= left_s;
      valid_r      <= valid_s;
      fill_r       <= fill_s;
      bram_en_r    <= bram_en_s;
      bram_we_r    <= bram_we_s;
      bram_addr_r  <= bram_addr_s;
      bram_wdata_r <= bram_wdata_s;
      word_out_r   <= word_out_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
    end
  end

endmodule

// File: tb/tb_apply_bound_mask_32bit.sv
// Scoreboard bench for apply_bound_mask_32bit: one instance at read latency 1,
// one at read latency 3, each backed by a small BRAM model.
module tb_apply_bound_mask_32bit;

  localparam int K_RD   = 0;
  localparam int K_WR   = 1;
  localparam int K_DONE = 2;
  localparam int K_IDLE = 3;

  typedef struct {
    int          kind;
    int          cyc;
    logic [12:0] addr;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trig_a = 1'b0, trig_b = 1'b0;
  logic [12:0] op_addr = 13'd0;
  logic [4:0]  op_idx = 5'd0;
  logic        op_lr = 1'b0, op_valid = 1'b0, op_fill = 1'b0;

  logic        en_a, we_a, busy_a, done_a, en_b, we_b, busy_b, done_b;
  logic [12:0] addr_a, addr_b;
  logic [31:0] wdata_a, word_a, rdata_a, wdata_b, word_b, rdata_b;
  logic [31:0] pa0 = 32'd0, pb0 = 32'd0, pb1 = 32'd0, pb2 = 32'd0;
  logic [31:0] mem_a [0:8191];
  logic [31:0] mem_b [0:8191];

  int   cyc = 0;
  int   n_pass = 0, n_tot = 0;
  bit   final_req = 1'b0, final_done = 1'b0;
  ent_t qa[$];
  ent_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apply_bound_mask_32bit #(.ADDR_WIDTH(13), .RD_LATENCY(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_trig(trig_a), .i_bram_addr(op_addr),
    .i_bound_index(op_idx), .i_left_or_right(op_lr), .i_is_bound_valid(op_valid),
    .i_fill_value(op_fill), .o_bram_en(en_a), .o_bram_we(we_a), .o_bram_addr(addr_a),
    .o_bram_wdata(wdata_a), .i_bram_rdata(rdata_a), .o_word_out(word_a),
    .o_busy(busy_a), .o_done(done_a));

  apply_bound_mask_32bit #(.ADDR_WIDTH(13), .RD_LATENCY(3)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_trig(trig_b), .i_bram_addr(op_addr),
    .i_bound_index(op_idx), .i_left_or_right(op_lr), .i_is_bound_valid(op_valid),
    .i_fill_value(op_fill), .o_bram_en(en_b), .o_bram_we(we_b), .o_bram_addr(addr_b),
    .o_bram_wdata(wdata_b), .i_bram_rdata(rdata_b), .o_word_out(word_b),
    .o_busy(busy_b), .o_done(done_b));

  // Read-only BRAM models with 1- and 3-cycle output pipelines.
  always @(posedge clk) begin
    if (en_a && !we_a) pa0 <= mem_a[addr_a];
    if (en_b && !we_b) pb0 <= mem_b[addr_b];
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign rdata_a = pa0;
  assign rdata_b = pb2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  function automatic int qsize(input int inst);
    return (inst == 0) ? qa.size() : qb.size();
  endfunction

  function automatic ent_t qpop(input int inst);
    if (inst == 0) return qa.pop_front();
    else return qb.pop_front();
  endfunction

  function automatic ent_t qfront(input int inst);
    if (inst == 0) return qa[0];
    else return qb[0];
  endfunction

  task automatic push(input int inst, input int kind, input int c, input logic [12:0] a,
                      input logic [31:0] d);
    ent_t e;
    e.kind = kind; e.cyc = c; e.addr = a; e.data = d;
    if (inst == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  task automatic check_dut(input int inst, input logic en, input logic we, input logic [12:0] a,
                           input logic [31:0] wd, input logic [31:0] wo, input logic dn,
                           input logic bz);
    ent_t e;
    if (qsize(inst) > 0) begin
      e = qfront(inst);
      if (e.kind == K_IDLE && e.cyc == cyc) begin
        e = qpop(inst);
        chk("idle_outputs", {en, we, a, wd, wo, dn, bz}, 64'd0);
      end
    end
    if (en && !we) begin
      chk("read_expected", 64'(qsize(inst) > 0), 64'd1);
      if (qsize(inst) > 0) begin
        e = qpop(inst);
        chk("read_kind", 64'(e.kind), 64'(K_RD));
        chk("read_cycle", 64'(cyc), 64'(e.cyc));
        chk("read_addr", 64'(a), 64'(e.addr));
      end
    end
    if (we) begin
      chk("write_expected", 64'(qsize(inst) > 0), 64'd1);
      chk("write_en", 64'(en), 64'd1);
      if (qsize(inst) > 0) begin
        e = qpop(inst);
        chk("write_kind", 64'(e.kind), 64'(K_WR));
        chk("write_cycle", 64'(cyc), 64'(e.cyc));
        chk("write_addr", 64'(a), 64'(e.addr));
        chk("write_data", 64'(wd), 64'(e.data));
      end
    end
    if (dn) begin
      chk("done_expected", 64'(qsize(inst) > 0), 64'd1);
      if (qsize(inst) > 0) begin
        e = qpop(inst);
        chk("done_kind", 64'(e.kind), 64'(K_DONE));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("word_out", 64'(wo), 64'(e.data));
        chk("busy_in_done", 64'(bz), 64'd1);
      end
    end
  endtask

  // Monitor: samples both DUTs on the falling edge and retires scoreboard entries.
  initial begin
    forever begin
      @(negedge clk);
      check_dut(0, en_a, we_a, addr_a, wdata_a, word_a, done_a, busy_a);
      check_dut(1, en_b, we_b, addr_b, wdata_b, word_b, done_b, busy_b);
      if (final_req && !final_done) begin
        chk("queue_a_drained", 64'(qa.size()), 64'd0);
        chk("queue_b_drained", 64'(qb.size()), 64'd0);
        final_done = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input int inst, input logic [12:0] a, input logic [4:0] idx,
                       input logic lr, input logic v, input logic f, input logic [31:0] rd,
                       input logic [31:0] exp_word);
    int lat, c0;
    lat = (inst == 0) ? 1 : 3;
    if (inst == 0) mem_a[a] = rd;
    else mem_b[a] = rd;
    op_addr = a; op_idx = idx; op_lr = lr; op_valid = v; op_fill = f;
    c0 = cyc;
    push(inst, K_RD, c0 + 1, a, 32'd0);
    if (v) push(inst, K_WR, c0 + 2 + lat, a, exp_word);
    push(inst, K_DONE, c0 + 3 + lat, 13'd0, exp_word);
    if (inst == 0) trig_a = 1'b1;
    else trig_b = 1'b1;
    step();
    trig_a = 1'b0; trig_b = 1'b0;
    op_addr = ~a; op_idx = ~idx; op_lr = ~lr; op_valid = ~v; op_fill = ~f;
    repeat (lat + 3) step();
  endtask

  initial begin
    int c0;
    step();
    push(0, K_IDLE, cyc, 13'd0, 32'd0);
    push(1, K_IDLE, cyc, 13'd0, 32'd0);
    step();
    rst = 1'b0;
    step();

    do_op(0, 13'h0A5, 5'd4,  1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_001F);
    do_op(0, 13'h100, 5'd28, 1'b1, 1'b1, 1'b1, 32'h0000_00FF, 32'hF000_00FF);
    do_op(0, 13'h101, 5'd0,  1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000);
    do_op(0, 13'h102, 5'd31, 1'b0, 1'b1, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF);
    do_op(0, 13'h103, 5'd0,  1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_op(0, 13'h104, 5'd7,  1'b0, 1'b0, 1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    do_op(0, 13'h105, 5'd15, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_7FFF);
    do_op(0, 13'h106, 5'd15, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_FFFF);
    do_op(0, 13'h107, 5'd31, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 32'h8000_0000);

    // Trigger held high for ten cycles: exactly two operations.
    mem_a[13'h010] = 32'h0000_0000;
    op_addr = 13'h010; op_idx = 5'd4; op_lr = 1'b0; op_valid = 1'b1; op_fill = 1'b1;
    c0 = cyc;
    push(0, K_RD, c0 + 1, 13'h010, 32'd0);
    push(0, K_WR, c0 + 3, 13'h010, 32'h0000_001F);
    push(0, K_DONE, c0 + 4, 13'd0, 32'h0000_001F);
    push(0, K_RD, c0 + 6, 13'h010, 32'd0);
    push(0, K_WR, c0 + 8, 13'h010, 32'h0000_001F);
    push(0, K_DONE, c0 + 9, 13'd0, 32'h0000_001F);
    trig_a = 1'b1;
    repeat (10) step();
    trig_a = 1'b0;
    repeat (3) step();

    // Reset during WAIT: no write, outputs cleared, then a normal operation.
    mem_a[13'h020] = 32'h0000_0000;
    op_addr = 13'h020; op_idx = 5'd8; op_lr = 1'b0; op_valid = 1'b1; op_fill = 1'b1;
    c0 = cyc;
    push(0, K_RD, c0 + 1, 13'h020, 32'd0);
    trig_a = 1'b1;
    step();
    trig_a = 1'b0;
    step();
    rst = 1'b1;
    push(0, K_IDLE, cyc, 13'd0, 32'd0);
    step();
    rst = 1'b0;
    push(0, K_IDLE, cyc, 13'd0, 32'd0);
    step();
    push(0, K_IDLE, cyc, 13'd0, 32'd0);
    step();
    do_op(0, 13'h021, 5'd8, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_01FF);

    // Read latency 3 instance.
    do_op(1, 13'h0A5, 5'd4,  1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_001F);
    do_op(1, 13'h100, 5'd28, 1'b1, 1'b1, 1'b1, 32'h0000_00FF, 32'hF000_00FF);
    do_op(1, 13'h101, 5'd4,  1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFE0);
    do_op(1, 13'h102, 5'd9,  1'b1, 1'b0, 1'b0, 32'h5A5A_5A5A, 32'h5A5A_5A5A);

    repeat (3) step();
    final_req = 1'b1;
    repeat (3) step();
    if (!final_done) begin
      n_tot++;
      $display("FAIL final_check: monitor did not run the drain check");
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
